// File: rtl/udp_rx_frame_parser_pkg.sv
// rtl/udp_rx_frame_parser_pkg.sv - shared constants and helpers for the UDP rx frame parser
package udp_rx_frame_parser_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_HDR     = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  // Header word field layout (all fields are 16 bits wide)
  localparam int MAGIC_LSB = 0;
  localparam int SEQ_LSB   = 16;
  localparam int LEN_LSB   = 32;
  localparam int FIELD_W   = 16;

  localparam logic [15:0] DEFAULT_MAGIC = 16'hA55A;

  // Saturating increments: counters stick at all-ones
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/udp_rx_frame_parser.sv
// rtl/udp_rx_frame_parser.sv - validates and strips the app header, forwards payload with error flag
module udp_rx_frame_parser
  import udp_rx_frame_parser_pkg::*;
#(
  parameter int          DATA_W = 64,
  parameter logic [15:0] MAGIC  = DEFAULT_MAGIC
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  output logic              m_user,
  input  logic              m_ready,
  output logic [31:0]       frame_ok_cnt,
  output logic [31:0]       frame_err_cnt,
  output logic [15:0]       seq_gap_cnt,
  output logic [15:0]       last_seq
);

  logic [1:0]  state;
  logic [15:0] remaining;
  logic        have_seq;

  logic [15:0] hdr_magic;
  logic [15:0] hdr_seq;
  logic [15:0] hdr_len;
  logic        magic_ok;
  logic        s_acc;
  logic        rem_one;

  assign hdr_magic = s_data[MAGIC_LSB +: FIELD_W];
  assign hdr_seq   = s_data[SEQ_LSB   +: FIELD_W];
  assign hdr_len   = s_data[LEN_LSB   +: FIELD_W];
  assign magic_ok  = (hdr_magic == MAGIC);
  assign s_acc     = s_valid && s_ready;
  assign rem_one   = (remaining == 16'd1);

  // Only PAYLOAD waits on the output register; header and discard always accept
  always_comb begin
    s_ready = 1'b1;
    if (state == ST_PAYLOAD) begin
      s_ready = !m_valid || m_ready;
    end
  end

  // Frame FSM, sequence tracking and statistics
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= ST_HDR;
      remaining     <= 16'd0;
      have_seq      <= 1'b0;
      frame_ok_cnt  <= 32'd0;
      frame_err_cnt <= 32'd0;
      seq_gap_cnt   <= 16'd0;
      last_seq      <= 16'd0;
    end else if (s_acc) begin
      case (state)
        ST_HDR: begin
          if (!magic_ok) begin
            frame_err_cnt <= sat_inc32(frame_err_cnt);
            if (!s_last) begin
              state <= ST_DISCARD;
            end
          end else begin
            // 16-bit add wraps, so FFFF -> 0000 is not a gap
            if (have_seq && (hdr_seq != last_seq + 16'd1)) begin
              seq_gap_cnt <= sat_inc16(seq_gap_cnt);
            end
            last_seq <= hdr_seq;
            have_seq <= 1'b1;
            if (s_last) begin
              if (hdr_len == 16'd0) begin
                frame_ok_cnt <= sat_inc32(frame_ok_cnt);
              end else begin
                frame_err_cnt <= sat_inc32(frame_err_cnt);
              end
            end else if (hdr_len == 16'd0) begin
              frame_err_cnt <= sat_inc32(frame_err_cnt);
              state         <= ST_DISCARD;
            end else begin
              remaining <= hdr_len;
              state     <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          remaining <= remaining - 16'd1;
          if (rem_one) begin
            if (s_last) begin
              frame_ok_cnt <= sat_inc32(frame_ok_cnt);
              state        <= ST_HDR;
            end else begin
              frame_err_cnt <= sat_inc32(frame_err_cnt);
              state         <= ST_DISCARD;
            end
          end else if (s_last) begin
            frame_err_cnt <= sat_inc32(frame_err_cnt);
            state         <= ST_HDR;
          end
        end
        ST_DISCARD: begin
          if (s_last) begin
            state <= ST_HDR;
          end
        end
        default: state <= ST_HDR;
      endcase
    end
  end

  // Output register: load on accepted payload word, otherwise drain on m_ready
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_user  <= 1'b0;
    end else if (state == ST_PAYLOAD && s_acc) begin
      m_data  <= s_data;
      m_valid <= 1'b1;
      // Frame ends here if the count is exhausted or the datagram ended early
      m_last  <= rem_one || s_last;
      // Error when the count and the datagram boundary disagree
      m_user  <= rem_one ? !s_last : s_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udp_rx_frame_parser.sv
// tb/tb_udp_rx_frame_parser.sv - self-checking bench for udp_rx_frame_parser
module tb_udp_rx_frame_parser;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [63:0] s_data  = '0;
  logic        s_valid = 1'b0;
  logic        s_last  = 1'b0;
  logic        s_ready;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_user;
  logic        m_ready = 1'b1;
  logic [31:0] frame_ok_cnt;
  logic [31:0] frame_err_cnt;
  logic [15:0] seq_gap_cnt;
  logic [15:0] last_seq;

  udp_rx_frame_parser #(.DATA_W(64), .MAGIC(16'hA55A)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_last        (m_last),
    .m_user        (m_user),
    .m_ready       (m_ready),
    .frame_ok_cnt  (frame_ok_cnt),
    .frame_err_cnt (frame_err_cnt),
    .seq_gap_cnt   (seq_gap_cnt),
    .last_seq      (last_seq)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          seg;
    logic [63:0] data;
    logic        last;
    logic        exp_out;
    logic        exp_last;
    logic        exp_user;
  } vec_t;

  typedef struct {
    int          ok;
    int          err;
    int          gap;
    logic [15:0] ls;
  } seg_exp_t;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic        u;
  } out_t;

  vec_t     vecs[$];
  seg_exp_t seg_exp[5];
  out_t     outq[$];
  out_t     expq[$];
  out_t     held;
  logic     stalled = 1'b0;
  logic     bp_on   = 1'b0;
  int       checks   = 0;
  int       failures = 0;

  function automatic logic [63:0] hdr(input logic [15:0] mg, input logic [15:0] sq, input logic [15:0] ln);
    return {16'h0000, ln, sq, mg};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input int seg, input logic [63:0] d, input logic l,
                     input logic eo, input logic el, input logic eu);
    vec_t v;
    v.seg = seg; v.data = d; v.last = l; v.exp_out = eo; v.exp_last = el; v.exp_user = eu;
    vecs.push_back(v);
  endtask

  // Output monitor plus hold-stability check while stalled
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        if (!m_valid || m_data !== held.d || m_last !== held.l || m_user !== held.u) begin
          failures++;
          $display("FAIL hold_stable actual=%b/%h/%b/%b required=1/%h/%b/%b",
                   m_valid, m_data, m_last, m_user, held.d, held.l, held.u);
        end
      end
      if (m_valid && m_ready) begin
        out_t o;
        o.d = m_data; o.l = m_last; o.u = m_user;
        outq.push_back(o);
      end
      stalled = m_valid && !m_ready;
      held.d = m_data; held.l = m_last; held.u = m_user;
    end
  end

  // Random downstream backpressure
  always @(posedge sys_clk) begin
    if (bp_on) begin
      #1;
      m_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the word is accepted
  task automatic send_word(input logic [63:0] d, input logic l);
    int n;
    n = 0;
    s_data = d; s_last = l; s_valid = 1'b1;
    @(negedge sys_clk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge sys_clk);
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL s_ready_timeout actual=0 required=1");
    end
    @(posedge sys_clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge sys_clk); #1;
    sys_rst = 1'b1; s_valid = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
  endtask

  task automatic run_segment(input int s);
    reset_dut();
    outq.delete();
    expq.delete();
    m_ready = 1'b1;
    foreach (vecs[i]) begin
      if (vecs[i].seg == s) begin
        send_word(vecs[i].data, vecs[i].last);
        if (vecs[i].exp_out) begin
          out_t o;
          o.d = vecs[i].data; o.l = vecs[i].exp_last; o.u = vecs[i].exp_user;
          expq.push_back(o);
        end
      end
    end
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    chk($sformatf("seg%0d_out_count", s), 64'(outq.size()), 64'(expq.size()));
    foreach (expq[i]) begin
      if (i < outq.size()) begin
        chk($sformatf("seg%0d_out%0d_data", s, i), outq[i].d, expq[i].d);
        chk($sformatf("seg%0d_out%0d_last", s, i), 64'(outq[i].l), 64'(expq[i].l));
        chk($sformatf("seg%0d_out%0d_user", s, i), 64'(outq[i].u), 64'(expq[i].u));
      end
    end
    chk($sformatf("seg%0d_frame_ok_cnt", s), 64'(frame_ok_cnt), 64'(seg_exp[s].ok));
    chk($sformatf("seg%0d_frame_err_cnt", s), 64'(frame_err_cnt), 64'(seg_exp[s].err));
    chk($sformatf("seg%0d_seq_gap_cnt", s), 64'(seq_gap_cnt), 64'(seg_exp[s].gap));
    chk($sformatf("seg%0d_last_seq", s), 64'(last_seq), 64'(seg_exp[s].ls));
  endtask

  initial begin
    int n;

    // seg 0: good frame, seq 5, len 3
    add(0, hdr(16'hA55A, 16'h0005, 16'd3), 1'b0, 1'b0, 1'b0, 1'b0);
    add(0, 64'h0000_0000_0000_0A00, 1'b0, 1'b1, 1'b0, 1'b0);
    add(0, 64'h1111_2222_3333_0A01, 1'b0, 1'b1, 1'b0, 1'b0);
    add(0, 64'h0000_00FF_EEDD_0A02, 1'b1, 1'b1, 1'b1, 1'b0);
    seg_exp[0] = '{ok: 1, err: 0, gap: 0, ls: 16'h0005};
    // seg 1: short frame (len 4, last on 2nd word), then a header-only frame proves HDR
    add(1, hdr(16'hA55A, 16'h0006, 16'd4), 1'b0, 1'b0, 1'b0, 1'b0);
    add(1, 64'hB0B0_0000_0000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1, 64'hB0B0_0000_0000_0002, 1'b1, 1'b1, 1'b1, 1'b1);
    add(1, hdr(16'hA55A, 16'h0007, 16'd0), 1'b1, 1'b0, 1'b0, 1'b0);
    seg_exp[1] = '{ok: 1, err: 1, gap: 0, ls: 16'h0007};
    // seg 2: long frame, bad magic frame, then a good frame
    add(2, hdr(16'hA55A, 16'h0007, 16'd1), 1'b0, 1'b0, 1'b0, 1'b0);
    add(2, 64'hC0C0_0000_0000_0001, 1'b0, 1'b1, 1'b1, 1'b1);
    add(2, 64'hC0C0_0000_0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    add(2, 64'hC0C0_0000_0000_0003, 1'b1, 1'b0, 1'b0, 1'b0);
    add(2, hdr(16'h1234, 16'h0099, 16'd2), 1'b0, 1'b0, 1'b0, 1'b0);
    add(2, 64'hD0D0_0000_0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    add(2, 64'hD0D0_0000_0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
    add(2, hdr(16'hA55A, 16'h0008, 16'd2), 1'b0, 1'b0, 1'b0, 1'b0);
    add(2, 64'hE0E0_0000_0000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
    add(2, 64'hE0E0_0000_0000_0002, 1'b1, 1'b1, 1'b1, 1'b0);
    seg_exp[2] = '{ok: 1, err: 2, gap: 0, ls: 16'h0008};
    // seg 3: sequence wrap FFFE, FFFF, 0000 then gap to 0002 (header-only frames)
    add(3, hdr(16'hA55A, 16'hFFFE, 16'd0), 1'b1, 1'b0, 1'b0, 1'b0);
    add(3, hdr(16'hA55A, 16'hFFFF, 16'd0), 1'b1, 1'b0, 1'b0, 1'b0);
    add(3, hdr(16'hA55A, 16'h0000, 16'd0), 1'b1, 1'b0, 1'b0, 1'b0);
    add(3, hdr(16'hA55A, 16'h0002, 16'd0), 1'b1, 1'b0, 1'b0, 1'b0);
    seg_exp[3] = '{ok: 4, err: 0, gap: 1, ls: 16'h0002};
    // seg 4: header-only with len!=0, len 0 with payload, bad magic with last, then good len 1
    add(4, hdr(16'hA55A, 16'h000A, 16'd5), 1'b1, 1'b0, 1'b0, 1'b0);
    add(4, hdr(16'hA55A, 16'h000B, 16'd0), 1'b0, 1'b0, 1'b0, 1'b0);
    add(4, 64'hF0F0_0000_0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    add(4, hdr(16'hBEEF, 16'h0055, 16'd1), 1'b1, 1'b0, 1'b0, 1'b0);
    add(4, hdr(16'hA55A, 16'h000C, 16'd1), 1'b0, 1'b0, 1'b0, 1'b0);
    add(4, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, 1'b1, 1'b0);
    seg_exp[4] = '{ok: 1, err: 3, gap: 0, ls: 16'h000C};

    // Reset state
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_m_last_user", {62'd0, m_last, m_user}, 64'd0);
    chk("rst_counters", {frame_ok_cnt, frame_err_cnt}, 64'd0);
    chk("rst_gap_seq", {32'd0, seq_gap_cnt, last_seq}, 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge sys_clk); #1;

    for (int s = 0; s < 5; s++) begin
      run_segment(s);
    end

    // 16-word frame under random backpressure
    reset_dut();
    outq.delete();
    bp_on = 1'b1;
    send_word(hdr(16'hA55A, 16'h0020, 16'd16), 1'b0);
    for (int i = 0; i < 16; i++) begin
      send_word(64'hB000_0000_0000_0000 | 64'(i), (i == 15));
    end
    n = 0;
    while (outq.size() < 16 && n < 300) begin
      n++;
      @(negedge sys_clk);
    end
    bp_on = 1'b0;
    @(posedge sys_clk); #2;
    m_ready = 1'b1;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("bp_out_count", 64'(outq.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < outq.size()) begin
        chk($sformatf("bp_out%0d_data", i), outq[i].d, 64'hB000_0000_0000_0000 | 64'(i));
        chk($sformatf("bp_out%0d_last_user", i), {62'd0, outq[i].l, outq[i].u}, (i == 15) ? 64'd2 : 64'd0);
      end
    end
    chk("bp_frame_ok_cnt", 64'(frame_ok_cnt), 64'd1);
    chk("bp_frame_err_cnt", 64'(frame_err_cnt), 64'd0);

    // Reset mid-frame with an output word stalled in the register
    @(posedge sys_clk); #1;
    m_ready = 1'b0;
    send_word(hdr(16'hA55A, 16'h0021, 16'd8), 1'b0);
    send_word(64'h7777_0000_0000_0001, 1'b0);
    @(negedge sys_clk);
    chk("midrst_pre_m_valid", 64'(m_valid), 64'd1);
    chk("midrst_pre_ok", 64'(frame_ok_cnt), 64'd1);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_m_data", m_data, 64'd0);
    chk("midrst_m_last_user", {62'd0, m_last, m_user}, 64'd0);
    chk("midrst_counters", {frame_ok_cnt, frame_err_cnt}, 64'd0);
    chk("midrst_gap_seq", {32'd0, seq_gap_cnt, last_seq}, 64'd0);
    outq.delete();
    m_ready = 1'b1;
    @(posedge sys_clk); #1;
    send_word(hdr(16'hA55A, 16'h0050, 16'd0), 1'b1);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("postrst_no_output", 64'(outq.size()), 64'd0);
    chk("postrst_frame_ok_cnt", 64'(frame_ok_cnt), 64'd1);
    chk("postrst_last_seq", 64'(last_seq), 64'h0050);
    chk("postrst_gap", 64'(seq_gap_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
